arb_rr16_al: RTL and testbench



---
 rtl/arb_rr16_al.sv | 167 ++++++++++++++++
 tb/tb_arb_rr16_al.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr16_al.sv
// arb_rr16_al: 16-requester round-robin arbiter with active-low one-hot
// requests and grants. A single registered FSM (IDLE/GRANT) owns every
// output, so nothing on req_n reaches an output without passing a flop.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant that
// is held for MAX_HOLD cycles is revoked, and the agent is masked until it
// raises its request.
module arb_rr16_al #(
  parameter int unsigned MAX_HOLD = 64,
  parameter logic [3:0]  RST_PTR  = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_n,
  output logic [15:0] gnt_n,
  output logic [3:0]  gnt_idx,
  output logic        gnt_vld,
  output logic        to_pulse
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  gnt_idx_q;
  logic [15:0] gnt_n_q;
  logic        gnt_vld_q;

  logic [15:0] elig_s;
  logic [4:0]  pick_s;
  logic        pick_found_s;
  logic [3:0]  pick_idx_s;
  logic [3:0]  ptr_d;

  // First eligible agent at or after ptr, wrapping modulo 16.
  // Result is {found, index}.
  function automatic logic [4:0] rr_pick(input logic [15:0] elig, input logic [3:0] ptr);
    logic [3:0] cand;
    rr_pick = 5'd0;
    // Walk from the farthest candidate down, so the closest one is the last to win.
    for (int k = 15; k >= 0; k--) begin
      cand = ptr + 4'(k);
      if (elig[cand]) begin
        rr_pick = {1'b1, cand};
      end
    end
  endfunction

  // Active-low one-hot decode of a grant index.
  function automatic logic [15:0] dec_n(input logic [3:0] idx);
    dec_n = ~(16'h0001 << idx);
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [7:0]  cnt_q;
  logic [15:0] mask_q;
  logic        to_pulse_q;
  logic [7:0]  cnt_inc_s;
  logic        hold_hit_s;

  // Masked agents are excluded until they raise their request.
  always_comb begin
    elig_s = ~req_n & ~mask_q;
  end

  // Saturating hold counter increment and MAX_HOLD hit detection.
  always_comb begin
    cnt_inc_s  = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
    hold_hit_s = ({1'b0, cnt_q} + 9'd1) >= {1'b0, MAX_HOLD_C};
  end

  assign to_pulse = to_pulse_q;
`else
  // Every requesting agent is eligible.
  always_comb begin
    elig_s = ~req_n;
  end

  assign to_pulse = 1'b0;
`endif

  // Priority search result and the pointer value that follows the current owner.
  always_comb begin
    pick_s       = rr_pick(elig_s, ptr_q);
    pick_found_s = pick_s[4];
    pick_idx_s   = pick_s[3:0];
    ptr_d        = gnt_idx_q + 4'd1;
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= RST_PTR;
      gnt_idx_q <= 4'd0;
      gnt_n_q   <= 16'hFFFF;
      gnt_vld_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= 8'd0;
      mask_q     <= 16'h0000;
      to_pulse_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      to_pulse_q <= 1'b0;
      // A masked agent is forgiven as soon as its request is seen high.
      mask_q     <= mask_q & ~req_n;
`endif
      case (state_q)
        IDLE: begin
          if (pick_found_s) begin
            gnt_idx_q <= pick_idx_s;
            gnt_n_q   <= dec_n(pick_idx_s);
            gnt_vld_q <= 1'b1;
            state_q   <= GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (req_n[gnt_idx_q]) begin
            // Normal release; wins over a simultaneous MAX_HOLD hit.
            gnt_idx_q <= 4'd0;
            gnt_n_q   <= 16'hFFFF;
            gnt_vld_q <= 1'b0;
            ptr_q     <= ptr_d;
            state_q   <= IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (hold_hit_s) begin
            // Forced revoke: pulse, mask the offender, advance as for a release.
            gnt_idx_q  <= 4'd0;
            gnt_n_q    <= 16'hFFFF;
            gnt_vld_q  <= 1'b0;
            ptr_q      <= ptr_d;
            state_q    <= IDLE;
            to_pulse_q <= 1'b1;
            mask_q     <= (mask_q & ~req_n) | (16'h0001 << gnt_idx_q);
          end else begin
            cnt_q <= cnt_inc_s;
`else
          end else begin
            state_q <= GRANT;
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_idx_q <= 4'd0;
          gnt_n_q   <= 16'hFFFF;
          gnt_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_n   = gnt_n_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_arb_rr16_al.sv
// Self-checking bench for arb_rr16_al: directed scenarios plus a randomized
// run checked against a behavioural round-robin model.
module tb_arb_rr16_al;

  localparam int MAXH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_n;
  logic [15:0] gnt_n;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        to_pulse;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model state: owner is -1 when nobody holds the slot.
  int          m_ptr;
  int          m_owner;
  int          m_held;
  logic [15:0] m_mask;
  logic        m_pulse;

  arb_rr16_al #(.MAX_HOLD(MAXH), .RST_PTR(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .gnt_n(gnt_n),
    .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .to_pulse(to_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one rising edge given the inputs sampled there.
  task automatic model_edge(input logic [15:0] r, input logic rst);
    logic [15:0] old_mask;
    int a;
    m_pulse = 1'b0;
    if (!rst) begin
      m_ptr = 0; m_owner = -1; m_held = 0; m_mask = 16'h0000;
      return;
    end
    old_mask = m_mask;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) if (r[i]) m_mask[i] = 1'b0;
`endif
    if (m_owner < 0) begin
      for (int k = 0; k < 16; k++) begin
        a = (m_ptr + k) % 16;
        if (!r[a] && !old_mask[a]) begin
          m_owner = a; m_held = 1;
          break;
        end
      end
    end else if (r[m_owner]) begin
      m_ptr = (m_owner + 1) % 16;
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_held >= MAXH) begin
        m_pulse = 1'b1;
        m_mask[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
      end else begin
        m_held++;
      end
`endif
    end
  endtask

  function automatic logic [15:0] exp_gnt_n();
    if (m_owner < 0) return 16'hFFFF;
    return ~(16'h0001 << m_owner);
  endfunction

  // One clock: model follows the edge, outputs settle 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge(req_n, rst_n);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_n = 16'hFFFF;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++;
      if (gnt_n !== 16'hFFFF || gnt_vld !== 1'b0 || gnt_idx !== 4'd0 || to_pulse !== 1'b0) begin
        n_mis++;
        $display("FAIL reset_idle cyc%0d: gnt_n=%h vld=%b idx=%0d pulse=%b, required FFFF 0 0 0",
                 i, gnt_n, gnt_vld, gnt_idx, to_pulse);
      end
    end
  endtask

  task automatic test_two_agents();
    req_n = 16'hFFF6;
    cyc();
    n_cmp++;
    if (gnt_n !== 16'hFFFE || gnt_idx !== 4'd0 || gnt_vld !== 1'b1) begin
      n_mis++;
      $display("FAIL two_first: gnt_n=%h idx=%0d vld=%b, required FFFE 0 1", gnt_n, gnt_idx, gnt_vld);
    end
    req_n = 16'hFFF7;
    cyc();
    n_cmp++;
    if (gnt_n !== 16'hFFFF || gnt_vld !== 1'b0) begin
      n_mis++;
      $display("FAIL two_gap: gnt_n=%h vld=%b, required FFFF 0", gnt_n, gnt_vld);
    end
    cyc();
    n_cmp++;
    if (gnt_n !== 16'hFFF7 || gnt_idx !== 4'd3) begin
      n_mis++;
      $display("FAIL two_second: gnt_n=%h idx=%0d, required FFF7 3", gnt_n, gnt_idx);
    end
    req_n = 16'hFFFF;
    cyc();
  endtask

  task automatic test_wrap();
    req_n = 16'hBFFF;
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd14 || gnt_n !== 16'hBFFF) begin
      n_mis++;
      $display("FAIL wrap_14: gnt_n=%h idx=%0d, required BFFF 14", gnt_n, gnt_idx);
    end
    req_n = 16'hFFFF;
    cyc();
    req_n = 16'h7FFE;
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd15 || gnt_n !== 16'h7FFF) begin
      n_mis++;
      $display("FAIL wrap_15: gnt_n=%h idx=%0d, required 7FFF 15", gnt_n, gnt_idx);
    end
    req_n = 16'hFFFE;
    cyc();
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd0 || gnt_n !== 16'hFFFE) begin
      n_mis++;
      $display("FAIL wrap_0: gnt_n=%h idx=%0d, required FFFE 0", gnt_n, gnt_idx);
    end
    req_n = 16'hFFFF;
    cyc();
  endtask

  task automatic test_back_to_back();
    int a;
    int waits;
    rst_n = 1'b0; req_n = 16'hFFFF;
    cyc();
    rst_n = 1'b1; req_n = 16'h0000;
    for (int g = 0; g < 17; g++) begin
      a = g % 16;
      waits = 0;
      do begin
        cyc();
        waits++;
        n_cmp++;
        if ($countones(~gnt_n) > 1 || gnt_n !== exp_gnt_n()) begin
          n_mis++;
          $display("FAIL b2b_onehot g%0d: gnt_n=%h, required %h", g, gnt_n, exp_gnt_n());
        end
      end while (gnt_vld !== 1'b1 && waits < 5);
      n_cmp++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 4'(a) || waits != 1) begin
        n_mis++;
        $display("FAIL b2b_order g%0d: vld=%b idx=%0d idle=%0d, required 1 %0d 1",
                 g, gnt_vld, gnt_idx, waits, a);
      end
      cyc();
      n_cmp++;
      if (gnt_idx !== 4'(a) || gnt_vld !== 1'b1) begin
        n_mis++;
        $display("FAIL b2b_hold g%0d: idx=%0d vld=%b, required %0d 1", g, gnt_idx, gnt_vld, a);
      end
      req_n[a] = 1'b1;
      cyc();
      req_n[a] = 1'b0;
      n_cmp++;
      if (gnt_n !== 16'hFFFF) begin
        n_mis++;
        $display("FAIL b2b_release g%0d: gnt_n=%h, required FFFF", g, gnt_n);
      end
    end
    req_n = 16'hFFFF;
    cyc();
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req_n = 16'hFFDF;
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd5 || gnt_n !== 16'hFFDF) begin
      n_mis++;
      $display("FAIL rstmid_grant: gnt_n=%h idx=%0d, required FFDF 5", gnt_n, gnt_idx);
    end
    rst_n = 1'b0;
    cyc();
    n_cmp++;
    if (gnt_n !== 16'hFFFF || to_pulse !== 1'b0 || gnt_vld !== 1'b0) begin
      n_mis++;
      $display("FAIL rstmid_revoke: gnt_n=%h pulse=%b vld=%b, required FFFF 0 0", gnt_n, to_pulse, gnt_vld);
    end
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd5 || gnt_n !== 16'hFFDF) begin
      n_mis++;
      $display("FAIL rstmid_regrant: gnt_n=%h idx=%0d, required FFDF 5", gnt_n, gnt_idx);
    end
    req_n = 16'hFFFF;
    cyc();
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; req_n = 16'hFFFF;
    cyc();
    rst_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
    req_n = ~16'h0084;
    cyc();
    for (int i = 0; i < MAXH; i++) begin
      n_cmp++;
      if (gnt_idx !== 4'd2 || to_pulse !== 1'b0) begin
        n_mis++;
        $display("FAIL to_hold c%0d: idx=%0d pulse=%b, required 2 0", i, gnt_idx, to_pulse);
      end
      cyc();
    end
    n_cmp++;
    if (gnt_n !== 16'hFFFF || to_pulse !== 1'b1) begin
      n_mis++;
      $display("FAIL to_revoke: gnt_n=%h pulse=%b, required FFFF 1", gnt_n, to_pulse);
    end
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd7 || to_pulse !== 1'b0 || gnt_vld !== 1'b1) begin
      n_mis++;
      $display("FAIL to_next: idx=%0d pulse=%b vld=%b, required 7 0 1", gnt_idx, to_pulse, gnt_vld);
    end
    req_n = ~16'h0004;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++;
      if (gnt_n !== 16'hFFFF) begin
        n_mis++;
        $display("FAIL to_masked c%0d: gnt_n=%h, required FFFF", i, gnt_n);
      end
    end
    req_n = 16'hFFFF;
    cyc();
    req_n = ~16'h0004;
    cyc();
    n_cmp++;
    if (gnt_idx !== 4'd2 || gnt_vld !== 1'b1) begin
      n_mis++;
      $display("FAIL to_unmask: idx=%0d vld=%b, required 2 1", gnt_idx, gnt_vld);
    end
`else
    req_n = ~16'h0004;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_cmp++;
      if (gnt_idx !== 4'd2 || gnt_vld !== 1'b1 || to_pulse !== 1'b0) begin
        n_mis++;
        $display("FAIL nto_hold c%0d: idx=%0d vld=%b pulse=%b, required 2 1 0", i, gnt_idx, gnt_vld, to_pulse);
      end
    end
`endif
    req_n = 16'hFFFF;
    cyc();
  endtask

  task automatic test_random();
    logic [15:0] flip;
    for (int c = 0; c < 600; c++) begin
      flip = 16'h0000;
      for (int b = 0; b < 16; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      req_n = req_n ^ flip;
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      cyc();
      n_cmp++;
      if (gnt_n !== exp_gnt_n() || gnt_vld !== (m_owner >= 0) ||
          gnt_idx !== ((m_owner >= 0) ? 4'(m_owner) : 4'd0) || to_pulse !== m_pulse) begin
        n_mis++;
        $display("FAIL random c%0d: gnt_n=%h idx=%0d vld=%b pulse=%b, required %h %0d %b %b",
                 c, gnt_n, gnt_idx, gnt_vld, to_pulse, exp_gnt_n(),
                 (m_owner >= 0) ? m_owner : 0, (m_owner >= 0), m_pulse);
      end
    end
    rst_n = 1'b1;
    req_n = 16'hFFFF;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    req_n = 16'hFFFF;
    m_ptr = 0; m_owner = -1; m_held = 0; m_mask = 16'h0000; m_pulse = 1'b0;
    test_reset();
    test_two_agents();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
